// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared states, sel codes and request type for the memory bus arbiter
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        S_ARB_IDLE     = 2'd0,
        S_ARB_ISSUE    = 2'd1,
        S_ARB_WAIT_ACK = 2'd2
    } arb_state_e;

    localparam logic [2:0]  SEL_BYTE      = 3'b000;
    localparam logic [2:0]  SEL_HALF      = 3'b001;
    localparam logic [2:0]  SEL_WORD      = 3'b010;
    localparam logic [31:0] RESET_PATTERN = 32'hFFFFFFFF;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  sel;
    } bus_req_t;

endpackage

// File: rtl/arb_req_buf.sv
// rtl/arb_req_buf.sv - one-entry request buffer per master; valid doubles as the master's stall
module arb_req_buf
    import mem_bus_arbiter_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_reset,
    input  logic     stb_i,
    input  bus_req_t req_i,
    input  logic     clr_i,
    output logic     valid_o,
    output bus_req_t req_o
);

    logic     valid_q, valid_d;
    bus_req_t req_q, req_d;

    // A strobe arriving while the entry is occupied is dropped.
    always_comb begin
        valid_d = valid_q;
        req_d   = req_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (stb_i && !valid_q) begin
            valid_d = 1'b1;
            req_d   = req_i;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            req_q   <= '{we: 1'b0, addr: RESET_PATTERN, data: RESET_PATTERN, sel: SEL_WORD};
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    assign valid_o = valid_q;
    assign req_o   = req_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master to one-slave memory bus arbiter with registered outputs
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int          PRIORITY_MODE  = 0,
    parameter int          TIMEOUT_CYCLES = 0,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_m0_stb,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    input  logic [2:0]  i_m0_sel,
    output logic [31:0] o_m0_data,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    output logic        o_m0_stall,
    input  logic        i_m1_stb,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    input  logic [2:0]  i_m1_sel,
    output logic [31:0] o_m1_data,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic        o_m1_stall,
    output logic        o_s_stb,
    output logic        o_s_we,
    output logic [31:0] o_s_addr,
    output logic [31:0] o_s_data,
    output logic [2:0]  o_s_sel,
    input  logic [31:0] i_s_data,
    input  logic        i_s_ack,
    input  logic        i_s_stall
);

    arb_state_e  state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] cnt_q, cnt_d, cnt_inc;
    logic        s_stb_q, s_stb_d;
    bus_req_t    s_req_q, s_req_d;
    logic [1:0]  ack_q, ack_d, err_q, err_d;
    logic [31:0] rdata_q [2];
    logic [31:0] rdata_d [2];
    logic [1:0]  valid, clr, stb_in;
    bus_req_t    req_in  [2];
    bus_req_t    req_buf [2];

    assign stb_in    = {i_m1_stb, i_m0_stb};
    assign req_in[0] = '{we: i_m0_we, addr: i_m0_addr, data: i_m0_data, sel: i_m0_sel};
    assign req_in[1] = '{we: i_m1_we, addr: i_m1_addr, data: i_m1_data, sel: i_m1_sel};

    for (genvar i = 0; i < 2; i++) begin : g_buf
        arb_req_buf u_buf (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .stb_i   (stb_in[i]),
            .req_i   (req_in[i]),
            .clr_i   (clr[i]),
            .valid_o (valid[i]),
            .req_o   (req_buf[i])
        );
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        cnt_inc      = cnt_q + 32'd1;
        s_stb_d      = 1'b0;
        s_req_d      = s_req_q;
        ack_d        = 2'b00;
        err_d        = 2'b00;
        rdata_d      = rdata_q;
        clr          = 2'b00;
        case (state_q)
            S_ARB_IDLE: begin
                if (valid != 2'b00) begin
                    if (valid == 2'b11) begin
                        owner_d = (PRIORITY_MODE == 1) ? 1'b0 : ~last_grant_q;
                    end else begin
                        owner_d = valid[1];
                    end
                    state_d = S_ARB_ISSUE;
                end
            end
            S_ARB_ISSUE: begin
                if (!i_s_stall) begin
                    s_stb_d = 1'b1;
                    s_req_d = req_buf[owner_q];
                    cnt_d   = 32'd0;
                    state_d = S_ARB_WAIT_ACK;
                end
            end
            S_ARB_WAIT_ACK: begin
                // A timeout completes exactly like an ack, only with error data.
                if (i_s_ack || (TIMEOUT_CYCLES > 0 && cnt_inc == 32'(TIMEOUT_CYCLES))) begin
                    rdata_d[owner_q] = i_s_ack ? i_s_data : ERR_DATA;
                    err_d[owner_q]   = !i_s_ack;
                    ack_d[owner_q]   = 1'b1;
                    clr[owner_q]     = 1'b1;
                    last_grant_d     = owner_q;
                    state_d          = S_ARB_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = S_ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_ARB_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 32'd0;
            s_stb_q      <= 1'b0;
            s_req_q      <= '{we: 1'b0, addr: RESET_PATTERN, data: RESET_PATTERN, sel: SEL_WORD};
            ack_q        <= 2'b00;
            err_q        <= 2'b00;
            rdata_q[0]   <= 32'd0;
            rdata_q[1]   <= 32'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            s_stb_q      <= s_stb_d;
            s_req_q      <= s_req_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata_q[0]   <= rdata_d[0];
            rdata_q[1]   <= rdata_d[1];
        end
    end

    assign o_m0_data  = rdata_q[0];
    assign o_m1_data  = rdata_q[1];
    assign o_m0_ack   = ack_q[0];
    assign o_m1_ack   = ack_q[1];
    assign o_m0_err   = err_q[0];
    assign o_m1_err   = err_q[1];
    assign o_m0_stall = valid[0];
    assign o_m1_stall = valid[1];
    assign o_s_stb    = s_stb_q;
    assign o_s_we     = s_req_q.we;
    assign o_s_addr   = s_req_q.addr;
    assign o_s_data   = s_req_q.data;
    assign o_s_sel    = s_req_q.sel;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench: directed steps plus random traffic against a scoreboard
module tb_mem_bus_arbiter;

    localparam logic [31:0] ERR_PAT = 32'hDEADBEEF;
    localparam int          TMO     = 8;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  sel;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  stb;
    req_t        drv [2];
    logic [31:0] s_rdata;
    logic        s_ack, s_stall;

    wire [31:0] mdat [2][2];
    wire [1:0]  mack [2];
    wire [1:0]  merr [2];
    wire [1:0]  mstall [2];
    wire        s_stb_w [2];
    wire        s_we_w [2];
    wire [31:0] s_addr_w [2];
    wire [31:0] s_data_w [2];
    wire [2:0]  s_sel_w [2];

    mem_bus_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(TMO), .ERR_DATA(ERR_PAT)) dut_rr (
        .i_clk(clk), .i_reset(rst),
        .i_m0_stb(stb[0]), .i_m0_we(drv[0].we), .i_m0_addr(drv[0].addr), .i_m0_data(drv[0].data), .i_m0_sel(drv[0].sel),
        .o_m0_data(mdat[0][0]), .o_m0_ack(mack[0][0]), .o_m0_err(merr[0][0]), .o_m0_stall(mstall[0][0]),
        .i_m1_stb(stb[1]), .i_m1_we(drv[1].we), .i_m1_addr(drv[1].addr), .i_m1_data(drv[1].data), .i_m1_sel(drv[1].sel),
        .o_m1_data(mdat[0][1]), .o_m1_ack(mack[0][1]), .o_m1_err(merr[0][1]), .o_m1_stall(mstall[0][1]),
        .o_s_stb(s_stb_w[0]), .o_s_we(s_we_w[0]), .o_s_addr(s_addr_w[0]), .o_s_data(s_data_w[0]), .o_s_sel(s_sel_w[0]),
        .i_s_data(s_rdata), .i_s_ack(s_ack), .i_s_stall(s_stall)
    );

    mem_bus_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(0), .ERR_DATA(ERR_PAT)) dut_fp (
        .i_clk(clk), .i_reset(rst),
        .i_m0_stb(stb[0]), .i_m0_we(drv[0].we), .i_m0_addr(drv[0].addr), .i_m0_data(drv[0].data), .i_m0_sel(drv[0].sel),
        .o_m0_data(mdat[1][0]), .o_m0_ack(mack[1][0]), .o_m0_err(merr[1][0]), .o_m0_stall(mstall[1][0]),
        .i_m1_stb(stb[1]), .i_m1_we(drv[1].we), .i_m1_addr(drv[1].addr), .i_m1_data(drv[1].data), .i_m1_sel(drv[1].sel),
        .o_m1_data(mdat[1][1]), .o_m1_ack(mack[1][1]), .o_m1_err(merr[1][1]), .o_m1_stall(mstall[1][1]),
        .o_s_stb(s_stb_w[1]), .o_s_we(s_we_w[1]), .o_s_addr(s_addr_w[1]), .o_s_data(s_data_w[1]), .o_s_sel(s_sel_w[1]),
        .i_s_data(s_rdata), .i_s_ack(s_ack), .i_s_stall(s_stall)
    );

    int          cyc, checks, errors, d;
    bit          slave_en, use_fixed;
    logic [31:0] fixed_rdata;
    int          ack_lat, ack_cnt;
    bit          pv [2];
    req_t        preq [2];
    int          owner_exp, stb_cyc, ackdrv_cyc, stb_count;
    int          ack_count [2];
    logic [31:0] last_ack_data [2];
    logic        last_ack_err [2];
    logic [31:0] exp_data;
    logic        exp_err;
    int          grant_log [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic req_t rnd_req();
        req_t r;
        r.we   = ($urandom_range(0, 1) == 1);
        r.addr = $urandom;
        r.data = $urandom;
        r.sel  = 3'($urandom_range(0, 2));
        return r;
    endfunction

    task automatic issue(input int m, input req_t r);
        stb[m]  = 1'b1;
        drv[m]  = r;
        pv[m]   = 1'b1;
        preq[m] = r;
    endtask

    // Advances one clock, plays the slave, and scores every observed ack, stall and slave strobe.
    task automatic tick();
        int own;
        @(posedge clk);
        #1;
        cyc++;
        stb   = 2'b00;
        s_ack = 1'b0;
        for (int m = 0; m < 2; m++) begin
            if (mack[d][m]) begin
                ack_count[m]++;
                last_ack_data[m] = mdat[d][m];
                last_ack_err[m]  = merr[d][m];
                chk("ack_owner", m, owner_exp);
                chk("ack_data", mdat[d][m], exp_data);
                chk("ack_err", 32'(merr[d][m]), 32'(exp_err));
                chk("ack_latency", cyc, slave_en ? ackdrv_cyc + 1 : stb_cyc + TMO);
                pv[m]     = 1'b0;
                owner_exp = -1;
            end
        end
        chk("err_without_ack", 32'(merr[d] & ~mack[d]), 32'd0);
        for (int m = 0; m < 2; m++) chk("stall", 32'(mstall[d][m]), 32'(pv[m]));
        if (s_stb_w[d]) begin
            own = -1;
            stb_count++;
            chk("stb_overlap", owner_exp, -1);
            for (int m = 0; m < 2; m++)
                if (own < 0 && pv[m] && {s_we_w[d], s_addr_w[d], s_data_w[d], s_sel_w[d]} === preq[m]) own = m;
            chk("stb_match", 32'(own >= 0), 32'd1);
            grant_log.push_back(own);
            owner_exp = own;
            stb_cyc   = cyc;
            if (slave_en) ack_cnt = ack_lat;
            else begin
                exp_data = ERR_PAT;
                exp_err  = 1'b1;
            end
        end
        if (ack_cnt == 0) begin
            s_ack      = 1'b1;
            s_rdata    = use_fixed ? fixed_rdata : $urandom;
            exp_data   = s_rdata;
            exp_err    = 1'b0;
            ackdrv_cyc = cyc;
            ack_cnt    = -1;
        end else if (ack_cnt > 0) begin
            ack_cnt--;
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((pv[0] || pv[1]) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(pv[0] | pv[1]), 32'd0);
    endtask

    task automatic do_reset(input bit keep_slave);
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        owner_exp = -1;
        if (!keep_slave) ack_cnt = -1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        stb_count = 0;
        ack_count[0] = 0;
        ack_count[1] = 0;
        grant_log.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t r;
        int   t0, rel, last, win, n;
        rst = 1'b1; stb = 2'b00; drv[0] = '0; drv[1] = '0;
        s_ack = 1'b0; s_stall = 1'b0; s_rdata = 32'd0;
        cyc = 0; checks = 0; errors = 0; d = 0;
        slave_en = 1'b1; use_fixed = 1'b0; fixed_rdata = 32'd0;
        ack_lat = 1; ack_cnt = -1; owner_exp = -1;
        stb_cyc = 0; ackdrv_cyc = 0; exp_data = 32'd0; exp_err = 1'b0;

        // Reset state of both instances.
        do_reset(1'b0);
        for (int dd = 0; dd < 2; dd++) begin
            chk("rst_s_stb", 32'(s_stb_w[dd]), 32'd0);
            chk("rst_s_we", 32'(s_we_w[dd]), 32'd0);
            chk("rst_s_addr", s_addr_w[dd], 32'hFFFFFFFF);
            chk("rst_s_data", s_data_w[dd], 32'hFFFFFFFF);
            chk("rst_s_sel", 32'(s_sel_w[dd]), 32'h2);
            for (int m = 0; m < 2; m++) begin
                chk("rst_ack", 32'(mack[dd][m]), 32'd0);
                chk("rst_err", 32'(merr[dd][m]), 32'd0);
                chk("rst_stall", 32'(mstall[dd][m]), 32'd0);
                chk("rst_mdata", mdat[dd][m], 32'd0);
            end
        end

        // Single word read from m0 with a fixed slave reply.
        use_fixed = 1'b1; fixed_rdata = 32'h12345678; ack_lat = 1;
        r.we = 1'b0; r.addr = 32'h10; r.data = 32'h0; r.sel = 3'b010;
        issue(0, r);
        t0 = cyc;
        run_until_idle(30);
        chk("t1_stb_latency", stb_cyc, t0 + 3);
        chk("t1_stb_once", stb_count, 1);
        chk("t1_m0_data", last_ack_data[0], 32'h12345678);
        chk("t1_m0_acks", ack_count[0], 1);
        chk("t1_m1_acks", ack_count[1], 0);
        chk("t1_s_addr", s_addr_w[0], 32'h10);
        use_fixed = 1'b0;

        // Simultaneous requests after reset; an extra m1 strobe while stalled must be dropped.
        do_reset(1'b0);
        r.we = 1'b0; r.addr = 32'h20; r.data = 32'h0; r.sel = 3'b010;
        issue(0, r);
        r.we = 1'b1; r.addr = 32'h40; r.data = 32'hCAFEBABE; r.sel = 3'b010;
        issue(1, r);
        tick();
        stb[1] = 1'b1;
        drv[1] = '{we: 1'b0, addr: 32'h99, data: 32'h1111, sel: 3'b000};
        run_until_idle(40);
        chk("t2_grants", grant_log.size(), 2);
        chk("t2_first", grant_log[0], 0);
        chk("t2_second", grant_log[1], 1);
        chk("t2_m1_acks", ack_count[1], 1);

        // Contended rounds; a solo request by the round winner moves last_grant between rounds.
        for (int dd = 0; dd < 2; dd++) begin
            d = dd;
            do_reset(1'b0);
            last = 1;
            for (int k = 0; k < 4; k++) begin
                grant_log.delete();
                ack_lat = $urandom_range(0, 3);
                issue(0, rnd_req());
                issue(1, rnd_req());
                run_until_idle(60);
                win = (dd == 1) ? 0 : 1 - last;
                chk("t3_first", grant_log[0], win);
                chk("t3_second", grant_log[1], 1 - win);
                issue(win, rnd_req());
                run_until_idle(30);
                last = win;
            end
        end
        d = 0;

        // Slave stall held while in S_ISSUE.
        do_reset(1'b0);
        ack_lat = 1;
        s_stall = 1'b1;
        issue(0, rnd_req());
        repeat (6) tick();
        chk("t4_no_stb", stb_count, 0);
        s_stall = 1'b0;
        rel = cyc;
        tick();
        chk("t4_stb_at_release", stb_cyc, rel + 1);
        run_until_idle(30);
        chk("t4_stb_once", stb_count, 1);

        // Timeout with a silent slave, then a normal transaction from idle.
        do_reset(1'b0);
        slave_en = 1'b0;
        issue(1, rnd_req());
        run_until_idle(40);
        chk("t5_data", last_ack_data[1], ERR_PAT);
        chk("t5_err", 32'(last_ack_err[1]), 32'd1);
        slave_en = 1'b1;
        issue(0, rnd_req());
        t0 = cyc;
        run_until_idle(30);
        chk("t5_idle_latency", stb_cyc, t0 + 3);

        // Reset during S_WAIT_ACK; the late slave ack must be ignored.
        do_reset(1'b0);
        ack_lat = 3;
        issue(0, rnd_req());
        n = 0;
        while (stb_count == 0 && n < 20) begin
            tick();
            n++;
        end
        chk("t6_stb_seen", stb_count, 1);
        do_reset(1'b1);
        repeat (6) tick();
        chk("t6_no_ack", ack_count[0] + ack_count[1], 0);
        chk("t6_s_stb", 32'(s_stb_w[0]), 32'd0);
        chk("t6_s_we", 32'(s_we_w[0]), 32'd0);
        chk("t6_s_addr", s_addr_w[0], 32'hFFFFFFFF);
        chk("t6_s_data", s_data_w[0], 32'hFFFFFFFF);
        chk("t6_s_sel", 32'(s_sel_w[0]), 32'h2);

        // Random traffic from both masters with random slave stall and ack latency.
        do_reset(1'b0);
        for (int i = 0; i < 400; i++) begin
            for (int m = 0; m < 2; m++)
                if (!pv[m] && $urandom_range(0, 2) == 0) issue(m, rnd_req());
            s_stall = ($urandom_range(0, 3) == 0);
            ack_lat = $urandom_range(0, 3);
            tick();
        end
        s_stall = 1'b0;
        run_until_idle(60);
        chk("t7_traffic", 32'(stb_count > 20), 32'd1);
        chk("t7_balance", stb_count, ack_count[0] + ack_count[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
